motor_deadtime_insert: RTL
==========================

Name: motor_deadtime_insert

Overview:
- Gate-drive dead-time inserter placed directly downstream of each motor control instance's 6-bit phase command, between the motor command and the power-stage pads.
- Guarantees that the high-side and low-side switches of a phase are never on together, with a programmable both-off gap whenever a switch is released.
- Flags illegal shoot-through requests.
- One instance per motor; dead time and fault clear come from the register bank.

Parameters:
- K_NPHASE, 3, number of half-bridge phases.
- K_DTWIDTH, 8, width of the dead-time counter and config field.

Ports:
- i_clk  in  1  main clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  bridge enable; low forces all switches off.
- i_deadtime  in  K_DTWIDTH  dead time in clock cycles (register bank field).
- i_fault_clr  in  1  single-cycle pulse that clears o_fault.
- i_cmd  in  2*K_NPHASE  requested switch states; bit 2k = phase k high side, bit 2k+1 = phase k low side.
- o_cmd  out  2*K_NPHASE  safe switch commands, same bit mapping as i_cmd.
- o_dead  out  K_NPHASE  phase k is currently in its dead-time window.
- o_fault  out  K_NPHASE  sticky: phase k received a both-sides request.

Behaviour:
- Each phase has an independent FSM with states IDLE, HS_ON, LS_ON and DEAD, plus a K_DTWIDTH down-counter cnt.
- o_cmd is decoded from the registered state:
  - HS_ON drives 01 (low side bit, high side bit).
  - LS_ON drives 10.
  - IDLE and DEAD drive 00.
- o_dead = (state == DEAD).
- Reset, asynchronous:
  - All phases go to DEAD with cnt = all ones.
  - o_cmd = 0, o_dead = all ones, o_fault = 0.
  - All switches are therefore off for 2^K_DTWIDTH cycles after reset release.
- Per-phase request req = {i_cmd[2k+1], i_cmd[2k]}:
  - 00 = off, 01 = HS, 10 = LS, 11 = illegal.
- Transitions, evaluated each clock while i_enable = 1:
  - IDLE:
    - req HS -> HS_ON; req LS -> LS_ON; req off -> IDLE.
    - req 11 -> IDLE and set fault.
  - HS_ON:
    - req HS -> stay.
    - Any other req (off, LS, 11) -> DEAD, load cnt = i_deadtime.
  - LS_ON: symmetric to HS_ON.
  - DEAD:
    - While cnt != 0: cnt decrements and the state stays DEAD, whatever req is.
    - When cnt == 0: req HS -> HS_ON; req LS -> LS_ON; req off -> IDLE; req 11 -> IDLE and set fault.
- Timing:
  - Latency from IDLE: i_cmd to o_cmd is 1 cycle.
  - After a switch is released, both outputs stay 0 for exactly i_deadtime+1 cycles before the opposite side may turn on.
  - i_deadtime = 0 still gives a 1-cycle gap.
- The request is not latched. The value of req at DEAD exit decides the next state; intermediate request changes during DEAD are ignored.
- i_deadtime is sampled only at counter load. Changing it mid-DEAD does not affect the running count.
- A direct HS->LS request never produces a cycle with both outputs active, and never skips DEAD.
- Fault handling:
  - fault is set in any cycle where req == 11 while i_enable = 1, in any state (including HS_ON, LS_ON and DEAD).
  - o_fault[k] is registered and sticky until i_fault_clr.
  - If set and clear occur in the same cycle, set wins.
  - A fault does not inhibit further operation; the 11 request itself is treated as off.
- i_enable = 0:
  - Every phase that is in HS_ON or LS_ON goes to DEAD with cnt = i_deadtime.
  - A phase in DEAD continues counting but cannot leave DEAD except to IDLE.
  - IDLE stays IDLE.
  - Fault detection is suppressed.
  - On re-enable, normal transitions resume, so dead time is respected across enable toggles.
- Invariant: o_cmd[2k] & o_cmd[2k+1] == 0 in every cycle, including through reset and reset release.

Test Plan:
1. Reset release with i_deadtime = 4, i_cmd = 6'b000001 held:
   - o_cmd = 0 for the first 256 cycles (cnt starts at 255, plus the exit cycle).
   - Then o_cmd[0] = 1; o_dead[0] falls in the same cycle.
2. Phase 0 in HS_ON, i_deadtime = 4, i_cmd switched to 6'b000010:
   - o_cmd = 0 and o_dead[0] = 1 for exactly 5 cycles.
   - o_cmd[1] = 1 on the 6th cycle; no cycle has bits 0 and 1 both set.
3. i_deadtime = 0, HS->LS toggle every 3 cycles on all phases:
   - Each side switch shows exactly 1 both-off cycle.
   - Phases switch independently with correct bit mapping.
4. i_cmd = 6'b110000 for 1 cycle while phase 2 is IDLE:
   - o_cmd[5:4] stay 00 and o_fault = 3'b100.
   - i_fault_clr pulse clears it.
   - An 11 request coinciding with i_fault_clr leaves o_fault set.
5. Phase 1 in LS_ON, i_deadtime = 10, i_enable dropped for 2 cycles then restored with LS still requested:
   - o_cmd[3] falls 1 cycle after i_enable falls.
   - o_cmd[3] returns only after 11 both-off cycles.
   - Changing i_deadtime to 2 mid-count does not shorten the gap.
6. Random i_cmd and i_deadtime with async reset asserted mid-DEAD:
   - Assertion-checked invariant of no simultaneous high and low side on any phase.
   - On reset, outputs clear immediately (asynchronously).

Source files
------------

// File: rtl/motor_deadtime_insert.sv
// Gate-drive dead-time inserter: per-phase FSM that keeps high and low side
// switches mutually exclusive with a programmable both-off gap on every release.
module motor_deadtime_phase #(
  parameter int K_DTWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 fault_clr,
  input  logic [K_DTWIDTH-1:0] deadtime,
  input  logic [1:0]           req,
  output logic [1:0]           cmd,
  output logic                 dead,
  output logic                 fault
);
  typedef enum logic [1:0] {IDLE, HS_ON, LS_ON, DEAD} state_t;

  localparam logic [1:0] REQ_HS = 2'b01;
  localparam logic [1:0] REQ_LS = 2'b10;

  state_t               state, state_nxt;
  logic [K_DTWIDTH-1:0] cnt, cnt_nxt;
  logic                 fault_set;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fault_set = enable && (req == 2'b11);
    case (state)
      IDLE: begin
        if (enable) begin
          if (req == REQ_HS)      state_nxt = HS_ON;
          else if (req == REQ_LS) state_nxt = LS_ON;
        end
      end
      HS_ON: begin
        if (!enable || req != REQ_HS) begin
          state_nxt = DEAD;
          cnt_nxt   = deadtime;
        end
      end
      LS_ON: begin
        if (!enable || req != REQ_LS) begin
          state_nxt = DEAD;
          cnt_nxt   = deadtime;
        end
      end
      DEAD: begin
        // Request is only looked at on the exit cycle; while disabled the
        // only way out is IDLE.
        if (cnt != '0)                      cnt_nxt   = cnt - 1'b1;
        else if (enable && req == REQ_HS)   state_nxt = HS_ON;
        else if (enable && req == REQ_LS)   state_nxt = LS_ON;
        else                                state_nxt = IDLE;
      end
      default: begin
        state_nxt = DEAD;
        cnt_nxt   = '1;
      end
    endcase
  end

  // Outputs are registered from state_nxt so the pads see flop outputs only,
  // with no decode glitch while the state bits change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DEAD;
      cnt   <= '1;
      cmd   <= 2'b00;
      dead  <= 1'b1;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cmd   <= {state_nxt == LS_ON, state_nxt == HS_ON};
      dead  <= (state_nxt == DEAD);
      if (fault_set)      fault <= 1'b1;
      else if (fault_clr) fault <= 1'b0;
    end
  end
endmodule

module motor_deadtime_insert #(
  parameter int K_NPHASE  = 3,
  parameter int K_DTWIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [K_DTWIDTH-1:0]  i_deadtime,
  input  logic                  i_fault_clr,
  input  logic [2*K_NPHASE-1:0] i_cmd,
  output logic [2*K_NPHASE-1:0] o_cmd,
  output logic [K_NPHASE-1:0]   o_dead,
  output logic [K_NPHASE-1:0]   o_fault
);
  for (genvar k = 0; k < K_NPHASE; k++) begin : g_ph
    motor_deadtime_phase #(.K_DTWIDTH(K_DTWIDTH)) u_ph (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .enable    (i_enable),
      .fault_clr (i_fault_clr),
      .deadtime  (i_deadtime),
      .req       (i_cmd[2*k +: 2]),
      .cmd       (o_cmd[2*k +: 2]),
      .dead      (o_dead[k]),
      .fault     (o_fault[k])
    );
  end
endmodule
